// File: rtl/piso_rr_sched_if.sv
// Handshake and serial-output bundle for piso_rr_sched: two valid/ready word
// sources on the input side, one framed serial line on the output side.
interface piso_rr_sched_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             ser_out;
  logic             ser_frame;
  logic             ser_id;
  logic             busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, ser_out, ser_frame, ser_id, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, ser_out, ser_frame, ser_id, busy
  );
endinterface

// File: rtl/piso_rr_sched.sv
// Two-requester round-robin scheduler feeding a shared MSB-first PISO shifter.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit after the LSB.
module piso_rr_sched #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  piso_rr_sched_if.slave  bus
);

`ifdef PISO_PARITY_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif
  localparam int BW = $clog2(FW);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state;
  logic [FW-1:0]    shreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             last_grant;
  logic             id;
  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] word_in;
  logic [FW-1:0]    frame_word;

  // Readies are held low during reset so nothing looks accepted while rst_n is low.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE && rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign word_in = grant1 ? bus.req1_data : bus.req0_data;

`ifdef PISO_PARITY_EN
  assign frame_word = {word_in, ^word_in};
`else
  assign frame_word = word_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      last_grant <= 1'b1;
      id         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0 || grant1) begin
            shreg      <= frame_word;
            id         <= grant1;
            last_grant <= grant1;
            bit_cnt    <= '0;
            state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          shreg <= {shreg[FW-2:0], 1'b0};
          if (bit_cnt == BW'(FW - 1)) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
            state   <= (GAP > 0) ? S_GAP : S_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (int'(gap_cnt) == GAP - 1) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.ser_frame  = (state == S_SHIFT);
  assign bus.ser_out    = (state == S_SHIFT) && shreg[FW-1];
  assign bus.ser_id     = id;
  assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_piso_rr_sched.sv
// Scoreboard bench for piso_rr_sched: a frame-level reference model queues expected
// frames at each predicted handshake, and an independent monitor checks the serial line.
module tb_piso_rr_sched;
  localparam int W = 4;
  localparam int G = 1;
`ifdef PISO_PARITY_EN
  localparam int FW = W + 1;
`else
  localparam int FW = W;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piso_rr_sched_if #(.WIDTH(W)) bus ();
  piso_rr_sched #(.WIDTH(W), .GAP(G)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic          id;
    logic [FW-1:0] bits;
  } frame_t;

  int       n_cmp = 0;
  int       n_bad = 0;
  frame_t   exp_q[$];
  int       busy_left = 0;
  int       cyc = 0;
  logic     last = 1'b1;
  logic     exp_id = 1'b0;
  logic     pend0 = 1'b0, pend1 = 1'b0;
  logic     acc0 = 1'b0, acc1 = 1'b0;
  logic [W-1:0] held0 = '0, held1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] frame_of(input logic [W-1:0] w);
`ifdef PISO_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // One clock cycle: drive inputs at the falling edge, check control outputs,
  // and advance the model over the upcoming rising edge.
  task automatic cycle(input logic r, input logic v0, input logic [W-1:0] d0,
                       input logic v1, input logic [W-1:0] d1);
    logic [W-1:0] a0, a1;
    logic         g0, g1;
    frame_t       f;
    @(negedge clk);
    a0 = pend0 ? held0 : d0;
    a1 = pend1 ? held1 : d1;
    rst_n = r;
    bus.req0_valid = v0;
    bus.req0_data  = a0;
    bus.req1_valid = v1;
    bus.req1_data  = a1;
    #1;
    cyc++;
    if (!r) begin
      exp_q.delete();
      busy_left = 0;
      last = 1'b1;
      exp_id = 1'b0;
      pend0 = 1'b0;
      pend1 = 1'b0;
    end
    g0 = 1'b0;
    g1 = 1'b0;
    if (r && busy_left == 0) begin
      if (v0 && v1) begin
        g0 = last;
        g1 = !last;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    check("ready0", bus.req0_ready, g0);
    check("ready1", bus.req1_ready, g1);
    check("busy", bus.busy, busy_left > 0);
    check("frame", bus.ser_frame, busy_left > G);
    check("id_hold", bus.ser_id, exp_id);
    if (!r) check("reset_out", bus.ser_out, 1'b0);
    acc0 = g0;
    acc1 = g1;
    if (r) begin
      if (g0 || g1) begin
        f.id   = g1;
        f.bits = frame_of(g1 ? a1 : a0);
        exp_q.push_back(f);
        last      = g1;
        exp_id    = g1;
        busy_left = FW + G;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      pend0 = v0 && !g0;
      pend1 = v1 && !g1;
      held0 = a0;
      held1 = a1;
    end
  endtask

  // Serial-line monitor, decoupled from the driver through exp_q.
  frame_t cur;
  int     idx = 0;
  logic   in_fr = 1'b0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      in_fr = 1'b0;
    end else if (bus.ser_frame) begin
      if (!in_fr) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: got frame bit %0b expected no frame at %0t", bus.ser_out, $time);
        end else begin
          cur   = exp_q.pop_front();
          idx   = 0;
          in_fr = 1'b1;
        end
      end
      if (in_fr) begin
        check("ser_out", bus.ser_out, cur.bits[FW-1-idx]);
        check("ser_id", bus.ser_id, cur.id);
        idx++;
        if (idx == FW) in_fr = 1'b0;
      end
    end else if (in_fr) begin
      n_cmp++;
      n_bad++;
      $display("FAIL short_frame: got %0d bits expected %0d at %0t", idx, FW, $time);
      in_fr = 1'b0;
    end
  end

  initial begin
    int   k, t0, t1;
    logic done0, done1;
    logic ids[$];
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;

    repeat (3) cycle(1'b0, 1'b0, '0, 1'b0, '0);

    // Single requester, 1010.
    k = 0;
    do begin
      cycle(1'b1, 1'b1, 4'b1010, 1'b0, '0);
      k++;
    end while (!acc0 && k < 20);
    repeat (8) cycle(1'b1, 1'b0, '0, 1'b0, '0);

    // Tie straight after reset: req0 first, req1 one frame period later.
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b0, '0);
    done0 = 1'b0; done1 = 1'b0; t0 = -1; t1 = -1;
    repeat (16) begin
      cycle(1'b1, !done0, 4'b1100, !done1, 4'b0011);
      if (acc0) t0 = cyc;
      if (acc1) t1 = cyc;
      done0 |= acc0;
      done1 |= acc1;
    end
    check("tie_first_req0", t0 < t1 && t0 > 0, 1'b1);
    check("frame_spacing", t1 - t0, FW + G + 1);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b0, '0);

    // Both held valid: grants alternate.
    repeat (4 * (FW + G + 1) + 2) begin
      cycle(1'b1, 1'b1, W'($urandom), 1'b1, W'($urandom));
      if (acc0 || acc1) ids.push_back(acc1);
    end
    check("alt_count", ids.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < ids.size(); i++) check("alt_id", ids[i], i % 2);
    repeat (FW + G + 2) cycle(1'b1, 1'b0, '0, 1'b0, '0);

    // Reset two bits into a req1 frame; word still presented afterwards.
    k = 0;
    do begin
      cycle(1'b1, 1'b0, '0, 1'b1, 4'b0110);
      k++;
    end while (!acc1 && k < 20);
    repeat (2) cycle(1'b1, 1'b0, '0, 1'b1, 4'b0110);
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b1, 4'b0110);
    k = 0;
    do begin
      cycle(1'b1, 1'b0, '0, 1'b1, 4'b0110);
      k++;
    end while (!acc1 && k < 20);
    check("replay_accepted", acc1, 1'b1);
    repeat (FW + G + 2) cycle(1'b1, 1'b0, '0, 1'b0, '0);

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      cycle($urandom_range(0, 299) != 0,
            $urandom_range(0, 9) < 6, W'($urandom),
            $urandom_range(0, 9) < 6, W'($urandom));
    end
    repeat (FW + G + 4) cycle(1'b1, 1'b0, '0, 1'b0, '0);
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
